// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: packed-BCD stopwatch counting rising edges of tick_in under start/stop/clear control.
// All-9s either wraps to zero with a one-cycle wrap pulse, or saturates and drops to HOLD.
module tick_bcd_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                wrap,
  output logic                at_max
);
  localparam int W = 4*DIGITS;
  localparam logic [W-1:0] MAX = {DIGITS{4'h9}};
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state;
  logic tick_d, rise, carry;
  logic [W-1:0] inc;
  assign rise = tick_in & ~tick_d;
  // digit-wise ripple: a 9 rolls to 0 and passes the carry upward
  always_comb begin
    inc = count;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[4*i+:4] = carry ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
      carry = carry & (count[4*i+:4] == 4'd9);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
      at_max  <= 1'b0;
      tick_d  <= 1'b1;
    end else begin
      tick_d <= tick_in;
      wrap   <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        count   <= '0;
        running <= 1'b0;
        at_max  <= 1'b0;
      end else if (stop) begin
        if (state == RUN) begin
          state   <= HOLD;
          running <= 1'b0;
        end
      end else if (start && state != RUN) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (state == RUN && rise) begin
        if (SATURATE && count == MAX) begin
          state   <= HOLD;
          running <= 1'b0;
        end else begin
          count  <= inc;
          wrap   <= count == MAX;
          at_max <= inc == MAX;
        end
      end
    end
  end
endmodule
